// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the decoupled instruction prefetcher.
// One FIFO entry pairs the fetched word with its fetch address + 4.
package inst_prefetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_fifo.sv
// Synchronous FIFO holding fetched {inst, pc+4} entries.
// Flush empties it in one cycle; the head is presented combinationally.
module prefetch_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage is not reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (rst && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Decoupled fetch front end: credit-limited in-order requests to imem,
// FIFO-buffered responses to decode, and redirect with in-flight discard.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_src,
  input  logic [31:0] add_res,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count;
  logic [CW:0]   credit_used;
  logic          req_fire, rsp_keep, pop;
  fetch_entry_t  head, push_data;

  // Credits cover buffered plus in-flight words, so every response has a slot.
  assign credit_used    = {1'b0, count} + {1'b0, inflight_q};
  assign imem_req_valid = rst && (credit_used < (CW+1)'(DEPTH)) && !pc_src;
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (discard_q == '0) && !pc_src;
  assign pop            = d_valid && d_ready && !pc_src;
  assign push_data      = '{inst: imem_rsp_data, pc4: rsp_pc_q + PC_STEP};

  assign d_valid = (count != '0);
  assign d_inst  = d_valid ? head.inst : NOP_INST;
  assign d_pc    = d_valid ? head.pc4  : 32'h0;

  always_comb begin
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    fetch_pc_d = req_fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
    rsp_pc_d   = rsp_keep ? rsp_pc_q + PC_STEP : rsp_pc_q;
    discard_d  = (imem_rsp_valid && discard_q != '0) ? discard_q - CW'(1) : discard_q;
    if (pc_src) begin
      fetch_pc_d = add_res;
      rsp_pc_d   = add_res;
      discard_d  = inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && imem_rsp_valid) begin
      rsp_credit_chk: assert (inflight_q != '0);
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rsp_keep),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (pc_src),
    .head_o      (head),
    .count_o     (count)
  );

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_inst_prefetch;
  import inst_prefetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pc_src, imem_req_ready, imem_rsp_valid, d_ready;
  logic [31:0] add_res, imem_rsp_data;
  logic        imem_req_valid, d_valid;
  logic [31:0] imem_addr, d_inst, d_pc;

  logic        w_pc_src, w_req_ready, w_rsp_valid, w_d_ready;
  logic [31:0] w_add_res, w_rsp_data;
  logic        w_req_valid, w_d_valid;
  logic [31:0] w_addr, w_d_inst, w_d_pc;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .add_res(add_res),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_inst(d_inst), .d_pc(d_pc)
  );

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .pc_src(w_pc_src), .add_res(w_add_res),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .d_valid(w_d_valid), .d_ready(w_d_ready), .d_inst(w_d_inst), .d_pc(w_d_pc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          rst_s, pc_src_s, dready_s, mready_s;
  logic [31:0] add_s;
  int          lat;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend[$];

  bit           armed = 0;
  logic [31:0]  m_fetch, m_rsp;
  int           m_inflight, m_discard;
  fetch_entry_t m_q[$];

  logic [31:0] fire_log[$];
  logic [31:0] w_log[$];
  bit          w_log_en = 0;
  bit          w_pend   = 0;
  logic [31:0] w_pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h200a0005;
      32'h0000_0004: return 32'h200b0007;
      32'h0000_0008: return 32'h200c0002;
      32'h0000_0040: return 32'h00400093;
      32'h0000_0080: return 32'h00800113;
      default:       return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step();
    bit exp_rv, exp_dv, fire;
    @(posedge clk);
    #1;
    cyc++;
    rst            = rst_s;
    pc_src         = pc_src_s;
    add_res        = add_s;
    d_ready        = dready_s;
    imem_req_ready = mready_s;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (!rst_s) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      pend.delete(0);
    end
    w_rsp_valid = rst_s && w_pend;
    w_rsp_data  = mem_word(w_pend_addr);
    #3;
    if (armed) begin
      exp_rv = rst_s && (m_q.size() + m_inflight < DEPTH) && !pc_src_s;
      exp_dv = (m_q.size() != 0);
      chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
      if (exp_rv) chk("req_addr", imem_addr, m_fetch);
      chk("d_valid", {31'h0, d_valid}, {31'h0, exp_dv});
      if (exp_dv) begin
        chk("d_inst", d_inst, m_q[0].inst);
        chk("d_pc", d_pc, m_q[0].pc4);
      end else begin
        chk("d_inst_idle", d_inst, 32'h0);
        chk("d_pc_idle", d_pc, 32'h0);
      end
    end else begin
      exp_rv = 1'b0;
    end
    if (rst_s && imem_req_valid && imem_req_ready) begin
      fire_log.push_back(imem_addr);
      pend.push_back('{addr: imem_addr, due: cyc + lat});
    end
    w_pend      = rst_s && w_req_valid;
    w_pend_addr = w_addr;
    if (w_log_en && w_req_valid) w_log.push_back(w_addr);

    fire = exp_rv && mready_s;
    if (!rst_s) begin
      armed      = 1;
      m_fetch    = 32'h0;
      m_rsp      = 32'h0;
      m_inflight = 0;
      m_discard  = 0;
      m_q.delete();
    end else if (pc_src_s) begin
      if (imem_rsp_valid) m_inflight--;
      m_discard = m_inflight;
      m_q.delete();
      m_fetch = add_s;
      m_rsp   = add_s;
    end else begin
      if (m_q.size() != 0 && dready_s) m_q.delete(0);
      if (imem_rsp_valid) begin
        m_inflight--;
        if (m_discard > 0) m_discard--;
        else begin
          m_q.push_back('{inst: imem_rsp_data, pc4: m_rsp + 32'd4});
          m_rsp = m_rsp + 32'd4;
        end
      end
      if (fire) begin
        m_inflight++;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int l, input bit dr);
    rst_s = 0; pc_src_s = 0; add_s = 32'h0; mready_s = 1;
    run(2);
    lat = l; dready_s = dr; rst_s = 1;
    fire_log.delete();
  endtask

  initial begin
    rst = 0; pc_src = 0; add_res = 0; imem_req_ready = 1; imem_rsp_valid = 0;
    imem_rsp_data = 0; d_ready = 1;
    w_pc_src = 0; w_add_res = 0; w_req_ready = 1; w_rsp_valid = 0; w_rsp_data = 0;
    w_d_ready = 1;
    rst_s = 0; pc_src_s = 0; add_s = 0; dready_s = 1; mready_s = 1; lat = 1;

    // Reset state, then zero-wait memory streaming three words
    run(2);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_d_valid", {31'h0, d_valid}, 32'h0);
    chk("rst_d_inst", d_inst, 32'h0);
    chk("rst_d_pc", d_pc, 32'h0);
    lat = 1; dready_s = 1; rst_s = 1; fire_log.delete();
    step();
    chk("t1_dv_c0", {31'h0, d_valid}, 32'h0);
    step();
    chk("t1_dv_c1", {31'h0, d_valid}, 32'h0);
    step();
    chk("t1_dv_c2", {31'h0, d_valid}, 32'h1);
    chk("t1_inst0", d_inst, 32'h200a0005);
    chk("t1_pc0", d_pc, 32'h4);
    step();
    chk("t1_inst1", d_inst, 32'h200b0007);
    chk("t1_pc1", d_pc, 32'h8);
    step();
    chk("t1_inst2", d_inst, 32'h200c0002);
    chk("t1_pc2", d_pc, 32'hC);

    // Decode stalled: credit stops issue at four
    do_reset(1, 0);
    run(8);
    chk("t2_nreq", fire_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < fire_log.size(); i++)
      chk("t2_addr", fire_log[i], 32'(i * 4));
    chk("t2_stalled", {31'h0, imem_req_valid}, 32'h0);
    dready_s = 1; fire_log.delete();
    run(2);
    chk("t2_refill_n", fire_log.size(), 32'd1);
    if (fire_log.size() > 0) chk("t2_refill_addr", fire_log[0], 32'h10);
    run(6);

    // Redirect with three late responses outstanding
    do_reset(4, 1);
    run(3);
    pc_src_s = 1; add_s = 32'h40;
    step();
    chk("t3_noreq_redir", {31'h0, imem_req_valid}, 32'h0);
    pc_src_s = 0;
    step();
    chk("t3_empty", {31'h0, d_valid}, 32'h0);
    chk("t3_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("t3_req_addr", imem_addr, 32'h40);
    run(5);
    chk("t3_dv", {31'h0, d_valid}, 32'h1);
    chk("t3_inst", d_inst, 32'h00400093);
    chk("t3_pc", d_pc, 32'h44);
    run(6);

    // Redirect coinciding with a response and a pop
    do_reset(1, 1);
    run(2);
    pc_src_s = 1; add_s = 32'h80;
    step();
    chk("t4_rsp_now", {31'h0, imem_rsp_valid}, 32'h1);
    chk("t4_dv_now", {31'h0, d_valid}, 32'h1);
    pc_src_s = 0;
    step();
    chk("t4_dv_next", {31'h0, d_valid}, 32'h0);
    chk("t4_addr", imem_addr, 32'h80);
    run(2);
    chk("t4_inst", d_inst, 32'h00800113);
    chk("t4_pc", d_pc, 32'h84);

    // Back-to-back redirects: later target wins
    do_reset(4, 1);
    run(2);
    pc_src_s = 1; add_s = 32'h100;
    step();
    add_s = 32'h200;
    step();
    pc_src_s = 0;
    for (int i = 0; i < 30 && !d_valid; i++) step();
    chk("t5_seen", {31'h0, d_valid}, 32'h1);
    chk("t5_pc", d_pc, 32'h204);
    run(4);

    // Address wrap on the second instance
    rst_s = 0;
    run(2);
    rst_s = 1; w_log.delete(); w_log_en = 1;
    run(3);
    w_log_en = 0;
    chk("wrap_n", w_log.size(), 32'd3);
    if (w_log.size() > 1) begin
      chk("wrap_addr0", w_log[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w_log[1], 32'h0);
    end
    chk("wrap_dv", {31'h0, w_d_valid}, 32'h1);
    chk("wrap_pc", w_d_pc, 32'h0);
    chk("wrap_inst", w_d_inst, mem_word(32'hFFFF_FFFC));

    // Reset mid-stream with a full FIFO
    do_reset(1, 0);
    run(8);
    chk("t6_full", {31'h0, d_valid}, 32'h1);
    rst_s = 0;
    step();
    step();
    chk("t6_dv", {31'h0, d_valid}, 32'h0);
    chk("t6_inst", d_inst, 32'h0);
    chk("t6_req", {31'h0, imem_req_valid}, 32'h0);
    rst_s = 1; dready_s = 1; fire_log.delete();
    step();
    chk("t6_refetch_n", fire_log.size(), 32'd1);
    if (fire_log.size() > 0) chk("t6_refetch", fire_log[0], 32'h0);
    run(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
- Fetch-side front end that replaces the single-register PC and IF/ID hand-off with a decoupled prefetcher.
- Issues in-order word requests to a latency-tolerant instruction memory.
- Buffers returned instructions in a small FIFO and presents {inst, pc+4} to decode under a valid/ready handshake.
- Sits between instruction memory and the decode stage; consumes the branch redirect (pc_src, target) produced by the memory stage.

Parameters:
DEPTH, 4, FIFO entries and maximum requests in flight (power of two, 2..16)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
pc_src  in  1  redirect strobe, one cycle
add_res  in  32  redirect target (word aligned)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address
imem_rsp_valid  in  1  response valid (in order, one per accepted request)
imem_rsp_data  in  32  instruction word
d_valid  out  1  instruction available to decode
d_ready  in  1  decode accepts
d_inst  out  32  instruction (32'h0 = nop when d_valid=0)
d_pc  out  32  fetch address + 4 (0 when d_valid=0)

Behaviour:
- Reset (rst=0 at posedge):
  - fetch_pc and rsp_pc are set to RESET_PC; FIFO count, inflight and discard are set to 0.
  - Outputs: imem_req_valid=0, d_valid=0, d_inst=0, d_pc=0.
  - Instruction memory shares this reset, so no pre-reset response arrives afterwards.
- Issue:
  - imem_req_valid = (count + inflight < DEPTH) && !pc_src.
  - imem_addr = fetch_pc.
  - On a request handshake: fetch_pc += 4 (mod 2^32, wraps) and inflight += 1.
  - Discarded in-flight requests still consume credit, so a response always has a free slot.
- Response:
  - Every imem_rsp_valid decrements inflight.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {imem_rsp_data, rsp_pc+4} and set rsp_pc += 4.
- Output:
  - d_valid = count != 0; d_inst/d_pc show the FIFO head, or zeros when empty.
  - Pop on d_valid && d_ready.
  - Push and pop in the same cycle are legal; count is unchanged and entry order is preserved.
  - A response into an empty FIFO is visible on d_valid the next cycle (1-cycle latency).
- Redirect (pc_src=1 in cycle N); in cycle N+1:
  - FIFO is empty; fetch_pc = rsp_pc = add_res.
  - discard = inflight after applying cycle-N response and issue (no issue occurs in N).
  - A response arriving in cycle N is dropped; a pop in cycle N is ignored.
  - First request to add_res is raised in cycle N+1.
- Request withdrawal: imem_req_valid may drop without a handshake only in a redirect cycle. Otherwise imem_addr holds stable while valid && !ready.
- Back-to-back redirects: the later one wins; discard accumulates correctly.
- Invariants:
  - discard <= inflight <= DEPTH.
  - count + inflight <= DEPTH.
  - A response with inflight=0 is a protocol error; flag it with an assertion.
- Counter widths: count, inflight and discard are $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package holds: NOP_INST=32'h0, PC_STEP=32'd4, and the fetch_entry_t struct {inst[31:0], pc4[31:0]}.
- One sub-module, prefetch_fifo: synchronous FIFO with DEPTH and width 64, push/pop/flush, count, head output.
- Counters and redirect logic stay in inst_prefetch.

Test Plan:
- Zero-latency memory, d_ready=1, words 0x200a0005, 0x200b0007, 0x200c0002:
  - d_valid rises 2 cycles after reset release.
  - Decode sees those words in order with d_pc 4, 8, 12, one per cycle.
- d_ready=0 with memory always ready:
  - Exactly 4 requests issue (addresses 0x0..0xC), then imem_req_valid=0.
  - After d_ready=1, one new request issues per pop.
- Memory latency 3, 3 requests in flight, pc_src=1 with add_res=0x40:
  - The 3 late responses are dropped.
  - First d_valid carries inst at 0x40 with d_pc=0x44; FIFO is empty in the cycle after pc_src.
- pc_src asserted in the same cycle as imem_rsp_valid and a decode pop:
  - Neither the response nor the pop is visible.
  - Next request address is the target.
- Wrap: RESET_PC=32'hFFFF_FFFC:
  - Second request address is 0x0.
  - First d_pc is 0x0.
- rst=0 mid-stream with a full FIFO:
  - Next cycle d_valid=0, d_inst=0, imem_req_valid=0.
  - After release, refetch starts at RESET_PC.
